// File: rtl/decrypter_stream.sv
// Streaming decrypter: 7-bit ciphertext in, plaintext out through a DEPTH-entry FIFO; a null ends a message.
// Latency 1 cycle accept-to-head; in_ready is low when the FIFO is full, without a key, or while a message drains.
module decrypter_stream #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       key_in,
    input  logic             key_load,
    input  logic             in_valid,
    input  logic [6:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [6:0]       out_data,
    input  logic             out_ready,
    output logic             msg_done,
    output logic [CNT_W-1:0] msg_len,
    output logic             key_valid
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        NO_KEY = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] msg_len_q, msg_len_d;
    logic             msg_done_q, msg_done_d;
    logic [6:0]       mem_q [DEPTH];
    logic [6:0]       mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [6:0]       t;
    logic [6:0]       plain;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign in_ready  = (state_q == ACTIVE) && !fifo_full;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 7'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign msg_done  = msg_done_q;
    assign msg_len   = msg_len_q;
    assign key_valid = key_valid_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Even bits are inverted in place, odd bits rotate 1->3->5->1; a null always passes through.
    always_comb begin
        t     = in_data ^ key_q;
        plain = {~t[6], t[3], ~t[4], t[1], ~t[2], t[5], ~t[0]};
        if (in_data == 7'h00) begin
            plain = 7'h00;
        end
    end

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        cnt_d       = cnt_q;
        msg_len_d   = msg_len_q;
        msg_done_d  = 1'b0;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = plain;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end

        case (state_q)
            NO_KEY: begin
                if (key_load) begin
                    key_d       = key_in;
                    key_valid_d = 1'b1;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                // The decode above already used key_q, so a same-cycle load only affects later characters.
                if (key_load) begin
                    key_d = key_in;
                end
                if (push) begin
                    if (in_data == 7'h00) begin
                        state_d = FLUSH;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (wr_ptr_d == rd_ptr_d) begin
                    msg_done_d = 1'b1;
                    msg_len_d  = cnt_q;
                    cnt_d      = '0;
                    state_d    = ACTIVE;
                end
            end
            default: begin
                state_d = NO_KEY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= NO_KEY;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            cnt_q       <= '0;
            msg_len_q   <= '0;
            msg_done_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            cnt_q       <= cnt_d;
            msg_len_q   <= msg_len_d;
            msg_done_q  <= msg_done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
        end
    end
endmodule

// File: tb/tb_decrypter_stream.sv
// Scoreboarded bench for decrypter_stream: reset, decode, messages, backpressure, key switch, async reset.
module tb_decrypter_stream;
    logic       clk;
    logic       rst_n;
    logic [6:0] key_in;
    logic       key_load;
    logic       in_valid;
    logic [6:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [6:0] out_data;
    logic       out_ready;
    logic       msg_done;
    logic [7:0] msg_len;
    logic       key_valid;

    int         n_chk = 0;
    int         n_bad = 0;
    logic [6:0] sb[$];
    logic [6:0] sb_exp;
    logic [6:0] tb_key = 7'h00;

    decrypter_stream #(.DEPTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_load  (key_load),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .msg_done  (msg_done),
        .msg_len   (msg_len),
        .key_valid (key_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] model_dec(input logic [6:0] d, input logic [6:0] k);
        logic [6:0] x;
        logic [6:0] p;
        if (d == 7'h00) return 7'h00;
        x = d ^ k;
        p[0] = !x[0];
        p[2] = !x[2];
        p[4] = !x[4];
        p[6] = !x[6];
        p[3] = x[1];
        p[5] = x[3];
        p[1] = x[5];
        return p;
    endfunction

    // Handshakes are stable mid-cycle, so the negedge view decides what transfers on the next posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    sb_exp = sb.pop_front();
                    chk("sb_data", {25'd0, out_data}, {25'd0, sb_exp});
                end
            end
            if (in_valid && in_ready) sb.push_back(model_dec(in_data, tb_key));
            if (key_load) tb_key = key_in;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        key_load = 1'b0;
        sb.delete();
        tb_key = 7'h00;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_key(input logic [6:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    task automatic send(input logic [6:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        chk("send_accept", {31'd0, done}, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && out_valid; i++) tick();
        chk("drain_empty", {31'd0, out_valid}, 0);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        key_in    = 7'h00;
        key_load  = 1'b0;
        in_valid  = 1'b0;
        in_data   = 7'h00;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", {25'd0, out_data}, 0);
        chk("rst_msg_done", {31'd0, msg_done}, 0);
        chk("rst_msg_len", {24'd0, msg_len}, 0);
        chk("rst_key_valid", {31'd0, key_valid}, 0);

        // Basic decode
        do_reset();
        load_key(7'h2A);
        chk("t1_key_valid", {31'd0, key_valid}, 1);
        chk("t1_in_ready", {31'd0, in_ready}, 1);
        out_ready = 1'b1;
        send(7'h3E);
        chk("t1_vld_a", {31'd0, out_valid}, 1);
        chk("t1_data_a", {25'd0, out_data}, 32'h41);
        send(7'h3D);
        chk("t1_data_h", {25'd0, out_data}, 32'h48);
        drain();

        // No key yet: input is blocked
        do_reset();
        in_valid = 1'b1;
        in_data  = 7'h14;
        repeat (3) tick();
        chk("t2_in_ready", {31'd0, in_ready}, 0);
        chk("t2_out_valid", {31'd0, out_valid}, 0);
        load_key(7'h00);
        tick();
        in_valid = 1'b0;
        chk("t2_data", {25'd0, out_data}, 32'h41);
        drain();

        // Full message with terminator, then a second message
        do_reset();
        load_key(7'h2A);
        send(7'h3E);
        send(7'h3D);
        send(7'h00);
        chk("t3_flush_rdy", {31'd0, in_ready}, 0);
        chk("t3_null_head", {25'd0, out_data}, 0);
        tick();
        chk("t3_done", {31'd0, msg_done}, 1);
        chk("t3_len", {24'd0, msg_len}, 2);
        chk("t3_rdy_back", {31'd0, in_ready}, 1);
        tick();
        chk("t3_done_pulse", {31'd0, msg_done}, 0);
        send(7'h3E);
        send(7'h00);
        tick();
        chk("t3_done2", {31'd0, msg_done}, 1);
        chk("t3_len2", {24'd0, msg_len}, 1);
        drain();

        // Backpressure: full FIFO blocks input
        do_reset();
        load_key(7'h2A);
        out_ready = 1'b0;
        send(7'h3E);
        send(7'h3D);
        send(7'h11);
        send(7'h55);
        chk("t4_full_rdy", {31'd0, in_ready}, 0);
        in_valid = 1'b1;
        in_data  = 7'h7F;
        repeat (2) tick();
        chk("t4_blocked", {31'd0, in_ready}, 0);
        chk("t4_hold", {25'd0, out_data}, 32'h41);
        out_ready = 1'b1;
        send(7'h7F);
        drain();

        // Key switch in the same cycle as an accept
        in_valid = 1'b1;
        in_data  = 7'h3E;
        key_in   = 7'h00;
        key_load = 1'b1;
        tick();
        in_valid = 1'b0;
        key_load = 1'b0;
        chk("t5_old_key", {25'd0, out_data}, 32'h41);
        send(7'h14);
        chk("t5_new_key", {25'd0, out_data}, 32'h41);
        drain();

        // Async reset with data buffered
        out_ready = 1'b0;
        send(7'h14);
        send(7'h15);
        send(7'h16);
        chk("t6_buffered", {31'd0, out_valid}, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", {31'd0, out_valid}, 0);
        chk("t6_in_ready", {31'd0, in_ready}, 0);
        chk("t6_key_valid", {31'd0, key_valid}, 0);
        chk("t6_done", {31'd0, msg_done}, 0);
        sb.delete();
        tick();
        chk("t6_done_hold", {31'd0, msg_done}, 0);
        rst_n = 1'b1;
        tick();
        chk("t6_no_key", {31'd0, in_ready}, 0);
        chk("t6_empty", {31'd0, out_valid}, 0);
        chk("t6_sb", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/decrypter_stream.md
Name: decrypter_stream

Overview:
Streaming receive-side inverse of the 7-bit homomorphic private-key encrypter. It accepts encrypted 7-bit ASCII characters over a valid/ready handshake, decrypts them with a loaded key, and buffers the plaintext in a small FIFO toward the consumer. An encrypted null (7'h00) terminates a message; the block then drains and reports the message length.

Parameters:
DEPTH, 4, output FIFO entries; power of 2, >=2
CNT_W, 8, width of character counter / message length

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
key_in  input  7  private key value
key_load  input  1  load key_in into key register
in_valid  input  1  encrypted character present
in_data  input  7  encrypted character
in_ready  output  1  block accepts in_data this cycle
out_valid  output  1  FIFO head valid
out_data  output  7  decrypted character (FIFO head)
out_ready  input  1  consumer takes FIFO head
msg_done  output  1  one-cycle pulse: terminator drained
msg_len  output  CNT_W  non-null characters in last completed message
key_valid  output  1  key register loaded since reset

Behaviour:
- Reset (async, rst_n=0): state NO_KEY, key register 0, FIFO empty, counter 0. Outputs: in_ready=0, out_valid=0, out_data=0, msg_done=0, msg_len=0, key_valid=0.
- Decrypt (combinational on accept): t = in_data ^ key. Plaintext p: p0=~t0, p2=~t2, p4=~t4, p6=~t6, p3=t1, p5=t3, p1=t5. Exception: in_data==7'h00 decodes to 7'h00 regardless of key (null pass-through, terminator).
- Accept: a transfer occurs when in_valid & in_ready are both high at a rising edge. in_ready = (state==ACTIVE) & !fifo_full. in_ready does not depend on out_ready; a full FIFO blocks even if a pop happens in the same cycle.
- Latency: a character accepted at edge N is at the FIFO head and visible at the output with out_valid=1 after edge N (when the FIFO was empty). Order is preserved.
- Pop: occurs when out_valid & out_ready. Simultaneous push and pop with a non-empty FIFO keeps the occupancy unchanged. out_data is held stable while out_valid=1 and out_ready=0.
- FSM:
  - NO_KEY: key_load -> ACTIVE, key<=key_in, key_valid<=1.
  - ACTIVE: an accepted non-null character is pushed and the counter increments (saturates at 2^CNT_W-1). An accepted null is pushed and the state goes to FLUSH; the counter is not incremented.
  - FLUSH: in_ready=0. When the FIFO becomes empty (the terminator has been popped): msg_done=1 for one cycle, msg_len<=counter, counter<=0, state -> ACTIVE.
- key_load: honoured in NO_KEY and ACTIVE, ignored in FLUSH. In ACTIVE, a character accepted in the same cycle as key_load uses the old key; the new key applies from the next cycle.
- key_valid stays 1 until reset.
- Reset mid-message: the FIFO contents, key and counter are discarded immediately (async); msg_done is not asserted.

Test Plan:
1. Reset, then key_load key_in=7'h2A; stream 7'h3E, 7'h3D with out_ready=1 -> out_data 7'h41 ('A') then 7'h48 ('H'), each 1 cycle after its accept.
2. Before any key_load, hold in_valid=1 with 7'h14 -> in_ready=0, out_valid=0. Then load key 7'h00 -> next accept yields 7'h41.
3. Key 7'h2A, send 7'h3E, 7'h3D, 7'h00, out_ready=1 -> outputs 41,48,00. in_ready=0 after the null is accepted. msg_done pulses 1 cycle after the null pops, msg_len=2, in_ready returns to 1.
4. out_ready=0, DEPTH=4, push 5 characters -> in_ready drops after the 4th push. Raise out_ready -> FIFO drains in order, in_ready reasserts, the 5th character is accepted.
5. Assert key_load (7'h00) in the same cycle as accepting 7'h3E under key 7'h2A -> output 7'h41. The next 7'h14 decodes to 7'h41 with the new key.
6. Drop rst_n with 3 characters buffered -> out_valid=0, in_ready=0, key_valid=0 immediately, no msg_done pulse.
